conv_controller_tiled: RTL and testbench

- Next-generation convolution loop controller for the MAC datapath.
- Adds stride, zero padding and OUT_PAR-wide output-channel parallelism over the single-channel controller.
- Adds valid/ready stall handling on both operand streams and output backpressure.
- Accumulates a full output window internally, so it needs no partial-sum scratchpad; sits between the operand fetch streams and the MAC array / output writer.

---
 rtl/conv_controller_tiled.sv | 242 ++++++++++++++++++++++++
 tb/tb_conv_controller_tiled.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_controller_tiled.sv
// Tiled convolution loop controller.
// Walks oy, ox, output-channel tile, ci, ky, kx. It issues one MAC step for
// each accepted operand pair. When a window is complete it presents OUT_PAR
// results and waits for the output writer to accept them.
module conv_controller_tiled #(
    parameter int FEATURE_MAP_WIDTH  = 16,
    parameter int FEATURE_MAP_HEIGHT = 16,
    parameter int INPUT_NB_CHANNELS  = 4,
    parameter int OUTPUT_NB_CHANNELS = 8,
    parameter int KERNEL_SIZE        = 3,
    parameter int STRIDE             = 1,
    parameter int PAD                = 1,
    parameter int OUT_PAR            = 2
) (
    input  logic               clk,
    input  logic               arst_n_in,
    input  logic               start,
    output logic               running,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic               b_valid,
    output logic               b_ready,
    output logic signed [31:0] in_x,
    output logic signed [31:0] in_y,
    output logic [31:0]        inch_out,
    output logic [31:0]        ky_out,
    output logic [31:0]        kx_out,
    output logic [31:0]        ch_out_base,
    output logic               pad_step,
    output logic               mac_valid,
    output logic               mac_accumulate_with_0,
    output logic               output_valid,
    input  logic               output_ready,
    output logic [31:0]        output_x,
    output logic [31:0]        output_y,
    output logic [31:0]        output_ch,
    output logic               fsm_done
);

    // Loop bounds as 32-bit constants so all index arithmetic stays 32 bits wide.
    localparam logic [31:0]        K_U   = 32'(KERNEL_SIZE);
    localparam logic [31:0]        S_U   = 32'(STRIDE);
    localparam logic [31:0]        CI_U  = 32'(INPUT_NB_CHANNELS);
    localparam logic [31:0]        CO_U  = 32'(OUTPUT_NB_CHANNELS);
    localparam logic [31:0]        PAR_U = 32'(OUT_PAR);
    localparam logic [31:0]        OW_U  =
        32'((FEATURE_MAP_WIDTH + 2 * PAD - KERNEL_SIZE) / STRIDE + 1);
    localparam logic [31:0]        OH_U  =
        32'((FEATURE_MAP_HEIGHT + 2 * PAD - KERNEL_SIZE) / STRIDE + 1);
    localparam logic signed [31:0] P_S   = 32'(PAD);
    localparam logic signed [31:0] W_S   = 32'(FEATURE_MAP_WIDTH);
    localparam logic signed [31:0] H_S   = 32'(FEATURE_MAP_HEIGHT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT_OUT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] oy_q, oy_d;
    logic [31:0] ox_q, ox_d;
    logic [31:0] cot_q, cot_d;
    logic [31:0] ci_q, ci_d;
    logic [31:0] ky_q, ky_d;
    logic [31:0] kx_q, kx_d;
    logic [31:0] out_x_q, out_x_d;
    logic [31:0] out_y_q, out_y_d;
    logic [31:0] out_ch_q, out_ch_d;

    logic signed [31:0] in_x_s;
    logic signed [31:0] in_y_s;
    logic               pad_raw;
    logic               in_run;
    logic               fire;
    logic               kx_last;
    logic               ky_last;
    logic               ci_last;
    logic               cot_last;
    logic               ox_last;
    logic               oy_last;
    logic               window_last;
    logic               final_out;

    // Input coordinate of the current step. It goes negative inside the top/left padding.
    assign in_x_s  = signed'(ox_q * S_U + kx_q) - P_S;
    assign in_y_s  = signed'(oy_q * S_U + ky_q) - P_S;
    assign pad_raw = (in_x_s < 0) || (in_x_s >= W_S) || (in_y_s < 0) || (in_y_s >= H_S);
    assign in_run  = (state_q == RUN);

    // A padded step needs no activation, so it only waits for the weights.
    assign fire = in_run && b_valid && (a_valid || pad_raw);

    assign kx_last     = (kx_q == K_U - 32'd1);
    assign ky_last     = (ky_q == K_U - 32'd1);
    assign ci_last     = (ci_q == CI_U - 32'd1);
    assign cot_last    = (cot_q == CO_U - PAR_U);
    assign ox_last     = (ox_q == OW_U - 32'd1);
    assign oy_last     = (oy_q == OH_U - 32'd1);
    assign window_last = kx_last && ky_last && ci_last;

    // The output being offered is the last of the layer when its registered coordinate is final.
    assign final_out = (out_y_q == OH_U - 32'd1) && (out_x_q == OW_U - 32'd1) &&
                       (out_ch_q == CO_U - PAR_U);

    // Plain index outputs. pad_step is only meaningful while stepping, so it is masked outside RUN.
    assign running     = (state_q != IDLE);
    assign in_x        = in_x_s;
    assign in_y        = in_y_s;
    assign inch_out    = ci_q;
    assign ky_out      = ky_q;
    assign kx_out      = kx_q;
    assign ch_out_base = cot_q;
    assign pad_step    = in_run && pad_raw;
    assign output_x    = out_x_q;
    assign output_y    = out_y_q;
    assign output_ch   = out_ch_q;

    // State, loop counters and captured output coordinate; cleared asynchronously.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q  <= IDLE;
            oy_q     <= '0;
            ox_q     <= '0;
            cot_q    <= '0;
            ci_q     <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
            out_x_q  <= '0;
            out_y_q  <= '0;
            out_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            oy_q     <= oy_d;
            ox_q     <= ox_d;
            cot_q    <= cot_d;
            ci_q     <= ci_d;
            ky_q     <= ky_d;
            kx_q     <= kx_d;
            out_x_q  <= out_x_d;
            out_y_q  <= out_y_d;
            out_ch_q <= out_ch_d;
        end
    end

    // Next-state, handshakes and the nested counter carry chain.
    always_comb begin
        state_d               = state_q;
        oy_d                  = oy_q;
        ox_d                  = ox_q;
        cot_d                 = cot_q;
        ci_d                  = ci_q;
        ky_d                  = ky_q;
        kx_d                  = kx_q;
        out_x_d               = out_x_q;
        out_y_d               = out_y_q;
        out_ch_d              = out_ch_q;
        a_ready               = 1'b0;
        b_ready               = 1'b0;
        mac_valid             = 1'b0;
        mac_accumulate_with_0 = 1'b0;
        output_valid          = 1'b0;
        fsm_done              = 1'b0;

        unique case (state_q)
            IDLE: begin
                oy_d  = '0;
                ox_d  = '0;
                cot_d = '0;
                ci_d  = '0;
                ky_d  = '0;
                kx_d  = '0;
                if (start) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                // Each ready depends only on the partner's valid. A valid never depends on a ready.
                b_ready               = a_valid || pad_raw;
                a_ready               = b_valid && !pad_raw;
                mac_valid             = fire;
                mac_accumulate_with_0 = fire && (ci_q == '0) && (ky_q == '0) && (kx_q == '0);

                if (fire) begin
                    if (!kx_last) begin
                        kx_d = kx_q + 32'd1;
                    end else begin
                        kx_d = '0;
                        if (!ky_last) begin
                            ky_d = ky_q + 32'd1;
                        end else begin
                            ky_d = '0;
                            if (!ci_last) begin
                                ci_d = ci_q + 32'd1;
                            end else begin
                                ci_d = '0;
                                if (!cot_last) begin
                                    cot_d = cot_q + PAR_U;
                                end else begin
                                    cot_d = '0;
                                    if (!ox_last) begin
                                        ox_d = ox_q + 32'd1;
                                    end else begin
                                        ox_d = '0;
                                        oy_d = oy_last ? 32'd0 : oy_q + 32'd1;
                                    end
                                end
                            end
                        end
                    end

                    // The window closes on this step. Latch its coordinate before the counters move on.
                    if (window_last) begin
                        out_x_d  = ox_q;
                        out_y_d  = oy_q;
                        out_ch_d = cot_q;
                        state_d  = WAIT_OUT;
                    end
                end
            end

            WAIT_OUT: begin
                // This state covers the one cycle of MAC latency. It also holds the result under backpressure.
                output_valid = 1'b1;
                if (output_ready) begin
                    if (final_out) begin
                        fsm_done = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_controller_tiled.sv
// Scoreboard bench for conv_controller_tiled.
// Instance u0 uses a 4x4 map with K=3, S=1, P=1, CI=1, CO=2.
// Instance u1 uses a 5x5 map with K=3, S=2, P=0, CI=2, CO=8.
module tb_conv_controller_tiled;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance u0 signals ----------------
    logic        u0_start, u0_running, u0_a_valid, u0_a_ready, u0_b_valid, u0_b_ready;
    logic [31:0] u0_in_x, u0_in_y, u0_inch, u0_ky, u0_kx, u0_ch_base;
    logic        u0_pad, u0_mac_valid, u0_mac_acc, u0_ov, u0_oready, u0_done;
    logic [31:0] u0_ox, u0_oy, u0_och;

    // ---------------- instance u1 signals ----------------
    logic        u1_start, u1_running, u1_a_valid, u1_a_ready, u1_b_valid, u1_b_ready;
    logic [31:0] u1_in_x, u1_in_y, u1_inch, u1_ky, u1_kx, u1_ch_base;
    logic        u1_pad, u1_mac_valid, u1_mac_acc, u1_ov, u1_oready, u1_done;
    logic [31:0] u1_ox, u1_oy, u1_och;

    conv_controller_tiled #(
        .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(4), .INPUT_NB_CHANNELS(1),
        .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(3), .STRIDE(1), .PAD(1), .OUT_PAR(2)
    ) u0 (
        .clk(clk), .arst_n_in(arst_n), .start(u0_start), .running(u0_running),
        .a_valid(u0_a_valid), .a_ready(u0_a_ready), .b_valid(u0_b_valid), .b_ready(u0_b_ready),
        .in_x(u0_in_x), .in_y(u0_in_y), .inch_out(u0_inch), .ky_out(u0_ky), .kx_out(u0_kx),
        .ch_out_base(u0_ch_base), .pad_step(u0_pad), .mac_valid(u0_mac_valid),
        .mac_accumulate_with_0(u0_mac_acc), .output_valid(u0_ov), .output_ready(u0_oready),
        .output_x(u0_ox), .output_y(u0_oy), .output_ch(u0_och), .fsm_done(u0_done)
    );

    conv_controller_tiled #(
        .FEATURE_MAP_WIDTH(5), .FEATURE_MAP_HEIGHT(5), .INPUT_NB_CHANNELS(2),
        .OUTPUT_NB_CHANNELS(8), .KERNEL_SIZE(3), .STRIDE(2), .PAD(0), .OUT_PAR(2)
    ) u1 (
        .clk(clk), .arst_n_in(arst_n), .start(u1_start), .running(u1_running),
        .a_valid(u1_a_valid), .a_ready(u1_a_ready), .b_valid(u1_b_valid), .b_ready(u1_b_ready),
        .in_x(u1_in_x), .in_y(u1_in_y), .inch_out(u1_inch), .ky_out(u1_ky), .kx_out(u1_kx),
        .ch_out_base(u1_ch_base), .pad_step(u1_pad), .mac_valid(u1_mac_valid),
        .mac_accumulate_with_0(u1_mac_acc), .output_valid(u1_ov), .output_ready(u1_oready),
        .output_x(u1_ox), .output_y(u1_oy), .output_ch(u1_och), .fsm_done(u1_done)
    );

    // Expected output records {x, y, ch}, one queue per instance.
    logic [95:0] q0[$];
    logic [95:0] q1[$];
    int          done0 = 0;
    int          done1 = 0;
    bit          gap_chk0 = 1'b0;
    bit          have_prev0 = 1'b0;
    int          last_acc0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic push_layer(input int inst, input int ow, input int oh, input int co, input int par);
        for (int y = 0; y < oh; y++)
            for (int x = 0; x < ow; x++)
                for (int c = 0; c < co; c += par) begin
                    if (inst == 0) q0.push_back({32'(x), 32'(y), 32'(c)});
                    else           q1.push_back({32'(x), 32'(y), 32'(c)});
                end
    endtask

    // Monitor u0: pop and compare each accepted output, and check fsm_done alignment and spacing.
    always @(negedge clk) begin
        logic [95:0] e;
        if (arst_n) begin
            if (u0_ov && u0_oready) begin
                if (q0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL u0 unexpected output: got (%0d,%0d,%0d), expected none", u0_ox, u0_oy, u0_och);
                end else begin
                    e = q0.pop_front();
                    check("u0 output_x", u0_ox, e[95:64]);
                    check("u0 output_y", u0_oy, e[63:32]);
                    check("u0 output_ch", u0_och, e[31:0]);
                    check("u0 fsm_done on accept", 32'(u0_done), 32'(q0.size() == 0));
                    $display("[TB] u0 out x=%0d y=%0d ch=%0d done=%0d", u0_ox, u0_oy, u0_och, u0_done);
                end
                if (gap_chk0 && have_prev0) check("u0 output spacing", 32'(cyc - last_acc0), 32'd10);
                have_prev0 = 1'b1;
                last_acc0  = cyc;
                if (u0_done) done0++;
            end else if (u0_done) begin
                check("u0 fsm_done without accept", 32'(u0_done), 32'd0);
            end
        end
    end

    // Monitor u1: pop and compare each accepted output.
    always @(negedge clk) begin
        logic [95:0] e;
        if (arst_n) begin
            if (u1_ov && u1_oready) begin
                if (q1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL u1 unexpected output: got (%0d,%0d,%0d), expected none", u1_ox, u1_oy, u1_och);
                end else begin
                    e = q1.pop_front();
                    check("u1 output_x", u1_ox, e[95:64]);
                    check("u1 output_y", u1_oy, e[63:32]);
                    check("u1 output_ch", u1_och, e[31:0]);
                    check("u1 fsm_done on accept", 32'(u1_done), 32'(q1.size() == 0));
                    $display("[TB] u1 out x=%0d y=%0d ch=%0d done=%0d", u1_ox, u1_oy, u1_och, u1_done);
                end
                if (u1_done) done1++;
            end else if (u1_done) begin
                check("u1 fsm_done without accept", 32'(u1_done), 32'd0);
            end
        end
    end

    // Pulse u0 start. On return the DUT is in RUN at step 0, 1 ns after the edge.
    task automatic start0();
        u0_start = 1'b1;
        @(posedge clk); #1;
        u0_start = 1'b0;
    endtask

    task automatic start1();
        u1_start = 1'b1;
        @(posedge clk); #1;
        u1_start = 1'b0;
    endtask

    task automatic wait_done0(input int prev);
        for (int i = 0; i < 3000 && done0 == prev; i++) @(negedge clk);
        check("u0 layer done pulses", 32'(done0 - prev), 32'd1);
        @(posedge clk); #1;
        check("u0 idle after done", 32'(u0_running), 32'd0);
    endtask

    task automatic wait_ov0(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!u0_ov && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!u0_ov) begin
            tests++; fails++;
            $display("FAIL %s: output_valid timeout, got 0 expected 1", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pads, accs, mvs, prev, step;
        arst_n = 1'b0;
        u0_start = 0; u0_a_valid = 0; u0_b_valid = 0; u0_oready = 0;
        u1_start = 0; u1_a_valid = 0; u1_b_valid = 0; u1_oready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state checks.
        check("reset running", 32'(u0_running), 32'd0);
        check("reset output_valid", 32'(u0_ov), 32'd0);
        check("reset mac_valid", 32'(u0_mac_valid), 32'd0);
        check("reset in_x", u0_in_x, 32'hFFFF_FFFF);
        check("reset output_x", u0_ox, 32'd0);
        check("reset a_ready", 32'(u0_a_ready), 32'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        u0_a_valid = 1; u0_b_valid = 1; u0_oready = 1;
        u1_a_valid = 1; u1_b_valid = 1; u1_oready = 1;
        @(posedge clk); #1;

        // Test 1: baseline layer, first-window padding, spacing of 10 cycles between outputs.
        $display("[TB] test 1 baseline");
        gap_chk0 = 1'b1; have_prev0 = 1'b0;
        push_layer(0, 4, 4, 2, 2);
        prev = done0;
        start0();
        pads = 0; accs = 0; mvs = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) check("t1 acc on first step", 32'(u0_mac_acc), 32'd1);
            mvs  += int'(u0_mac_valid);
            pads += int'(u0_pad && u0_mac_valid);
            accs += int'(u0_mac_acc);
        end
        check("t1 mac steps first window", 32'(mvs), 32'd9);
        check("t1 pad steps first window", 32'(pads), 32'd5);
        check("t1 acc count first window", 32'(accs), 32'd1);
        wait_done0(prev);
        gap_chk0 = 1'b0;

        // Test 2: weight stall in the middle of the first window.
        $display("[TB] test 2 b_valid stall");
        push_layer(0, 4, 4, 2, 2);
        prev = done0;
        start0();
        repeat (4) @(posedge clk);
        #1 u0_b_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2 stall mac_valid", 32'(u0_mac_valid), 32'd0);
            check("t2 stall kx", u0_kx, 32'd1);
            check("t2 stall ky", u0_ky, 32'd1);
            check("t2 stall a_ready", 32'(u0_a_ready), 32'd0);
            check("t2 stall b_ready", 32'(u0_b_ready), 32'd1);
        end
        @(posedge clk); #1 u0_b_valid = 1'b1;
        wait_done0(prev);

        // Test 3: output backpressure on the second output.
        $display("[TB] test 3 output backpressure");
        push_layer(0, 4, 4, 2, 2);
        prev = done0;
        start0();
        wait_ov0("t3 first output");
        @(posedge clk); #1 u0_oready = 1'b0;
        wait_ov0("t3 second output");
        for (int i = 0; i < 5; i++) begin
            check("t3 hold output_valid", 32'(u0_ov), 32'd1);
            check("t3 hold output_x", u0_ox, 32'd1);
            check("t3 hold output_y", u0_oy, 32'd0);
            check("t3 hold a_ready", 32'(u0_a_ready), 32'd0);
            check("t3 hold b_ready", 32'(u0_b_ready), 32'd0);
            check("t3 hold mac_valid", 32'(u0_mac_valid), 32'd0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1 u0_oready = 1'b1;
        wait_done0(prev);

        // Test 6: asynchronous reset mid-layer, then a clean restart.
        $display("[TB] test 6 mid-run reset");
        push_layer(0, 4, 4, 2, 2);
        start0();
        repeat (25) @(posedge clk);
        #3 arst_n = 1'b0;
        #1;
        check("t6 reset running", 32'(u0_running), 32'd0);
        check("t6 reset output_valid", 32'(u0_ov), 32'd0);
        check("t6 reset mac_valid", 32'(u0_mac_valid), 32'd0);
        check("t6 reset kx", u0_kx, 32'd0);
        check("t6 reset ky", u0_ky, 32'd0);
        check("t6 reset ch_out_base", u0_ch_base, 32'd0);
        check("t6 reset in_x", u0_in_x, 32'hFFFF_FFFF);
        check("t6 reset in_y", u0_in_y, 32'hFFFF_FFFF);
        check("t6 reset pad_step", 32'(u0_pad), 32'd0);
        check("t6 reset b_ready", 32'(u0_b_ready), 32'd0);
        check("t6 reset output_x", u0_ox, 32'd0);
        q0.delete();
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6 idle output_valid", 32'(u0_ov), 32'd0);
            check("t6 idle fsm_done", 32'(u0_done), 32'd0);
        end
        @(posedge clk); #1;
        push_layer(0, 4, 4, 2, 2);
        prev = done0;
        start0();
        check("t6 restart running", 32'(u0_running), 32'd1);
        check("t6 restart kx", u0_kx, 32'd0);
        check("t6 restart inch", u0_inch, 32'd0);
        check("t6 restart in_x", u0_in_x, 32'hFFFF_FFFF);
        wait_done0(prev);

        // Tests 4 and 5: stride 2 without padding, four channel tiles, CI=2.
        $display("[TB] test 4/5 stride and channel tiles");
        push_layer(1, 2, 2, 8, 2);
        prev = done1;
        start1();
        step = 0;
        for (int i = 0; i < 3000 && done1 == prev; i++) begin
            @(negedge clk);
            if (u1_mac_valid) begin
                check("t5 mac_accumulate_with_0", 32'(u1_mac_acc), 32'(step % 18 == 0));
                check("t4 pad_step", 32'(u1_pad), 32'd0);
                if (step == 72) begin
                    check("t4 in_x first step ox=1", u1_in_x, 32'd2);
                    check("t4 in_y first step ox=1", u1_in_y, 32'd0);
                    check("t4 ch_out_base first step ox=1", u1_ch_base, 32'd0);
                end
                step++;
            end
        end
        check("t4 layer done pulses", 32'(done1 - prev), 32'd1);
        check("t4 total mac steps", 32'(step), 32'd288);
        check("t4 outputs left", 32'(q1.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
